// File: rtl/l2bus_tx.sv
// l2bus_tx - L2 bus transmitter.
//
// Queues outbound bus commands from l2data, arbitrates for the shared
// snooping bus, drives command/tag/address/data during the owned bus cycle,
// checks the aggregated snoop nack and confirms completed own commands back
// to l2tag with the transaction id that was allocated for them.
//
// Bus cycle: 8 clk phases tracked by a free-running 3-bit counter that every
// bus agent keeps in lock-step. Grant is sampled at phase 7 for the next
// cycle; the owned cycle puts the command at phase 0 and data beat i at phase i.
//
// Command encoding (shared with the other bus agents):
//   BusRd=1, BusRdX=2, BusUpgr=3, Flush=4, Fill=5. L2 bus id = 2'd3.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               enqueue interface from l2data (req_ready = not full)
//   bus_req/bus_grant   arbitration
//   bus_*_o             command/tag/address/data driven during owned cycle
//   bus_hit/bus_nack    aggregated snoop result, sampled at phase 7
//   fill_valid/fill_tag response to one of our ids seen on the bus (frees id)
//   trans_*             confirmation pulse for completed own commands
//   snoop_addr/flush_hit  conflict check against queued/in-flight Flushes
//
// Optional feature: define L2BUS_TX_BACKOFF_EN to wait BACKOFF full bus
// cycles (with bus_req low) after a nack before re-arbitrating.
module l2bus_tx #(
    parameter int DEPTH   = 4,
    parameter int BACKOFF = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [2:0]   req_cmd,
    input  logic         req_own,
    input  logic [4:0]   req_tag,
    input  logic [25:0]  req_addr,
    input  logic [511:0] req_data,
    output logic         req_ready,
    output logic         bus_req,
    input  logic         bus_grant,
    output logic         bus_valid_o,
    output logic [2:0]   bus_cmd_o,
    output logic [4:0]   bus_tag_o,
    output logic [25:0]  bus_addr_o,
    output logic [63:0]  bus_data_o,
    input  logic         bus_hit,
    input  logic         bus_nack,
    input  logic         fill_valid,
    input  logic [2:0]   fill_tag,
    output logic         trans_valid,
    output logic [2:0]   trans_tag,
    output logic         trans_hit,
    input  logic [25:0]  snoop_addr,
    output logic         flush_hit
);

    localparam logic [2:0] CMD_BUSRD  = 3'd1;
    localparam logic [2:0] CMD_BUSRDX = 3'd2;
    localparam logic [2:0] CMD_FLUSH  = 3'd4;
    localparam logic [2:0] CMD_FILL   = 3'd5;
    localparam logic [1:0] BUSID_L2   = 2'd3;

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

    typedef struct packed {
        logic [2:0]   cmd;
        logic         own;
        logic [4:0]   tag;
        logic [25:0]  addr;
        logic [511:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, XMIT, BACKOFF_ST} state_t;

    // ---------------------------------------------------------------- phase
    logic [2:0] phase;

    always_ff @(posedge clk) begin
        if (rst) phase <= 3'd0;
        else     phase <= phase + 3'd1;
    end

    // ---------------------------------------------------------------- queue
    entry_t [DEPTH-1:0] q;
    logic   [DEPTH-1:0] q_vld;
    logic   [AW-1:0]    wr_ptr, rd_ptr;
    logic   [AW:0]      count;
    entry_t             head;
    logic               push, pop;

    state_t     state;
    logic [7:0] busy, busy_nxt;
    logic [2:0] cur_id;
    logic [BW-1:0] bo_cnt;

    assign req_ready = (count != (AW+1)'(DEPTH));
    assign push      = req_valid & req_ready;
    assign head      = q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_vld  <= '0;
        end else begin
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; q_vld qualifies every use.
    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= '{cmd: req_cmd, own: req_own, tag: req_tag,
                                 addr: req_addr, data: req_data};
    end

    // Head entry stays valid through XMIT until it pops, so an in-flight
    // Flush keeps reporting a conflict.
    always_comb begin
        flush_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (q_vld[i] && q[i].cmd == CMD_FLUSH && q[i].addr == snoop_addr)
                flush_hit = 1'b1;
    end

    // ---------------------------------------------------------------- id pool
    logic       head_needs_id, head_has_data, head_elig, id_free;
    logic [2:0] alloc_id;
    logic       alloc, xmit_end, nack_free;
    logic [2:0] beat_idx;
    logic [63:0] beat;

    assign head_needs_id = head.own & (head.cmd == CMD_BUSRD || head.cmd == CMD_BUSRDX);
    assign head_has_data = (head.cmd == CMD_FLUSH) || (head.cmd == CMD_FILL);
    assign id_free       = ~&busy;
    assign head_elig     = ~head_needs_id | id_free;

    always_comb begin
        alloc_id = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (!busy[i]) alloc_id = 3'(i);
    end

    assign alloc     = (state == REQ) && (phase == 3'd7) && bus_grant && head_needs_id;
    assign xmit_end  = (state == XMIT) && (phase == 3'd7);
    assign pop       = xmit_end & ~bus_nack;
    assign nack_free = xmit_end & bus_nack & head_needs_id;

    // Fill frees first, allocation last so a same-clk allocation is kept.
    always_comb begin
        busy_nxt = busy;
        if (fill_valid) busy_nxt[fill_tag] = 1'b0;
        if (nack_free)  busy_nxt[cur_id]   = 1'b0;
        if (alloc)      busy_nxt[alloc_id] = 1'b1;
    end

    // Beat for the next phase: beat 0 is loaded on the grant edge.
    assign beat_idx = (state == XMIT) ? phase + 3'd1 : 3'd0;
    assign beat     = head_has_data ? head.data[{beat_idx, 6'd0} +: 64] : 64'd0;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= '0;
            cur_id      <= '0;
            bo_cnt      <= '0;
            bus_req     <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_cmd_o   <= '0;
            bus_tag_o   <= '0;
            bus_addr_o  <= '0;
            bus_data_o  <= '0;
            trans_valid <= 1'b0;
            trans_tag   <= '0;
            trans_hit   <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            bus_valid_o <= 1'b0;
            trans_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0 && head_elig) begin
                        state   <= REQ;
                        bus_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (phase == 3'd7 && bus_grant) begin
                        state       <= XMIT;
                        bus_req     <= 1'b0;
                        cur_id      <= head_needs_id ? alloc_id : 3'd0;
                        bus_valid_o <= 1'b1;
                        bus_cmd_o   <= head.cmd;
                        bus_tag_o   <= head.own ? {BUSID_L2, (head_needs_id ? alloc_id : 3'd0)}
                                                : head.tag;
                        bus_addr_o  <= head.addr;
                        bus_data_o  <= beat;
                    end
                end
                XMIT: begin
                    if (phase != 3'd7) begin
                        bus_data_o <= beat;
                    end else begin
                        bus_cmd_o  <= '0;
                        bus_tag_o  <= '0;
                        bus_addr_o <= '0;
                        bus_data_o <= '0;
                        if (!bus_nack) begin
                            state       <= IDLE;
                            trans_valid <= head.own;
                            trans_tag   <= cur_id;
                            trans_hit   <= bus_hit;
                        end else begin
`ifdef L2BUS_TX_BACKOFF_EN
                            state  <= BACKOFF_ST;
                            bo_cnt <= '0;
`else
                            state   <= REQ;
                            bus_req <= 1'b1;
`endif
                        end
                    end
                end
                BACKOFF_ST: begin
                    // One count per completed bus cycle.
                    if (phase == 3'd7) begin
                        if (bo_cnt == BW'(BACKOFF - 1)) begin
                            state   <= REQ;
                            bus_req <= 1'b1;
                        end else begin
                            bo_cnt <= bo_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
